// File: rtl/lut_mem_dp.sv
// Dual-ported lookup memory: a bus side that snoops a 2-stage pass-through
// pipeline, and a user side with direct index access and registered read data.
module lut_mem_dp #(
   parameter int DEPTH        = 8,
   parameter int BASE_ADDR    = 0,
   parameter int DATA_WIDTH   = 16,
   parameter int BUS_WRITABLE = 1,
   localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [15:0]           addr_i,
   input  logic [15:0]           wdata_i,
   input  logic [15:0]           rdata_i,
   input  logic                  rw_i,
   input  logic                  valid_i,
   output logic [15:0]           addr_o,
   output logic [15:0]           wdata_o,
   output logic [15:0]           rdata_o,
   output logic                  rw_o,
   output logic                  valid_o,
   input  logic [AW-1:0]         user_addr_i,
   input  logic [DATA_WIDTH-1:0] user_wdata_i,
   input  logic                  user_we_i,
   output logic [DATA_WIDTH-1:0] user_rdata_o
);

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
      logic        rw;
      logic        valid;
   } bus_beat_t;

   // Window bounds held in 17 bits so BASE_ADDR+DEPTH-1 never wraps.
   localparam logic [16:0] WIN_LO = 17'(BASE_ADDR);
   localparam logic [16:0] WIN_HI = 17'(BASE_ADDR + DEPTH - 1);
   localparam logic [15:0] BASE16 = 16'(BASE_ADDR);

   bus_beat_t s1_q, s1_d, s2_q, s2_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [DATA_WIDTH-1:0] user_rdata_q, user_rdata_d;
   logic [DATA_WIDTH-1:0] bus_rd_val;
   logic [15:0]           bus_idx;
   logic                  bus_hit;

   always_comb begin
      bus_hit = valid_i && ({1'b0, addr_i} >= WIN_LO) && ({1'b0, addr_i} <= WIN_HI);
      bus_idx = addr_i - BASE16;
   end

   // Read muxes see mem_q, so both ports return the pre-write value on a collision.
   always_comb begin
      bus_rd_val   = '0;
      user_rdata_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (bus_idx == 16'(i)) bus_rd_val = mem_q[i];
         if (user_addr_i == AW'(i)) user_rdata_d = mem_q[i];
      end
   end

   // User write first, bus write second: the bus wins on a same-entry collision.
   always_comb begin
      mem_d = mem_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (user_we_i && (user_addr_i == AW'(i)))
            mem_d[i] = user_wdata_i;
         if ((BUS_WRITABLE != 0) && bus_hit && rw_i && (bus_idx == 16'(i)))
            mem_d[i] = wdata_i[DATA_WIDTH-1:0];
      end
   end

   always_comb begin
      s1_d.addr  = addr_i;
      s1_d.wdata = wdata_i;
      s1_d.rw    = rw_i;
      s1_d.valid = valid_i;
      s1_d.rdata = (bus_hit && !rw_i) ? 16'(bus_rd_val) : rdata_i;
      s2_d       = s1_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q         <= '0;
         s2_q         <= '0;
         user_rdata_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         s1_q         <= s1_d;
         s2_q         <= s2_d;
         user_rdata_q <= user_rdata_d;
         mem_q        <= mem_d;
      end
   end

   assign addr_o       = s2_q.addr;
   assign wdata_o      = s2_q.wdata;
   assign rdata_o      = s2_q.rdata;
   assign rw_o         = s2_q.rw;
   assign valid_o      = s2_q.valid;
   assign user_rdata_o = user_rdata_q;

endmodule
